forward_ctrl: RTL

Parametrised forwarding and hazard controller for the in-order integer pipeline; successor to the combinational EXE-stage forward selector. It keeps its own shadow pipeline of destination tags, fed from the ID stage, and drives the EXE-stage operand mux selects for any number of source operands and forwarding stages. It also detects load-use and no-forwarding hazards, raises the ID/IF stall, and counts stall cycles.

---
 rtl/fwd_pkg.sv | 21 ++
 rtl/fwd_match.sv | 37 +++
 rtl/forward_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller: shadow-pipeline tag layout,
// the register-file select code and a bubble constructor.
package fwd_pkg;

    // Tags carry a fixed-width destination; REG_W of the controller must not exceed it.
    localparam int FWD_DEST_W = 8;
    localparam int SEL_RF     = 0;

    typedef struct packed {
        logic [FWD_DEST_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
    } fwd_tag_t;

    function automatic fwd_tag_t fwd_bubble();
        fwd_tag_t t;
        t = '0;
        return t;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one source operand: per-entry match vector plus the
// 1-based index of the youngest (lowest) matching entry that may be selected.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NUM_ENT  = 2,
    parameter int ZERO_REG = 0,
    parameter int SW       = $clog2(NUM_ENT + 1)
) (
    input  logic [REG_W-1:0]                      src_i,
    input  logic [NUM_ENT-1:0][FWD_DEST_W-1:0]    dest_i,
    input  logic [NUM_ENT-1:0]                    wen_i,
    input  logic [NUM_ENT-1:0]                    blk_i,
    output logic [NUM_ENT-1:0]                    match_o,
    output logic [SW-1:0]                         sel_o
);

    logic                 src_zero;
    logic [NUM_ENT-1:0]   m;

    assign src_zero = (ZERO_REG != 0) && (src_i == '0);

    always_comb begin
        m     = '0;
        sel_o = '0;
        for (int i = 0; i < NUM_ENT; i++)
            m[i] = wen_i[i] && (dest_i[i] == FWD_DEST_W'(src_i)) && !src_zero;
        // Walk oldest to youngest so the youngest eligible producer is written last.
        for (int i = NUM_ENT - 1; i >= 0; i--)
            if (m[i] && !blk_i[i])
                sel_o = SW'(i + 1);
    end

    assign match_o = m;

endmodule

// File: rtl/forward_ctrl.sv
// EXE-stage forwarding select and ID hazard-stall controller with its own
// shadow pipeline of destination tags and a saturating stall counter.
module forward_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 3,
    parameter int FWD_STAGES = 2,
    parameter int ZERO_REG   = 0,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REG_W-1:0]           id_dest,
    input  logic                       id_wb_en,
    input  logic                       id_mem_read,
    input  logic                       fwd_en,
    input  logic                       mem_stall,
    input  logic                       flush,
    output logic [NUM_SRC*SEL_W-1:0]   sel,
    output logic                       hazard_stall,
    output logic [15:0]                stall_count
);

    localparam int HSW = $clog2(FWD_STAGES + 2);
    // A load sitting in stage 1 has no data yet, so it may match but never forward.
    localparam logic [FWD_STAGES-1:0] LD_BLK = FWD_STAGES'(1);

    logic [NUM_SRC-1:0][REG_W-1:0]      exe_src_q, exe_src_d;
    logic [NUM_SRC-1:0]                 exe_used_q, exe_used_d;
    fwd_tag_t                           exe_q, exe_d;
    fwd_tag_t [FWD_STAGES-1:0]          tag_q, tag_d;
    logic [15:0]                        cnt_q, cnt_d;

    logic [FWD_STAGES-1:0][FWD_DEST_W-1:0] tag_dest;
    logic [FWD_STAGES-1:0]              tag_wen, tag_ld;

    logic [NUM_SRC-1:0][FWD_STAGES-1:0] fwd_m;
    logic [NUM_SRC-1:0][SEL_W-1:0]      fwd_s;
    logic [NUM_SRC-1:0][FWD_STAGES:0]   hz_m;
    logic [NUM_SRC-1:0][HSW-1:0]        hz_s;
    logic [NUM_SRC-1:0]                 hz_op;

    always_comb begin
        tag_dest = '0;
        tag_wen  = '0;
        tag_ld   = '0;
        for (int i = 0; i < FWD_STAGES; i++) begin
            tag_dest[i] = tag_q[i].dest;
            tag_wen[i]  = tag_q[i].wb_en;
            tag_ld[i]   = tag_q[i].mem_read;
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_op
        fwd_match #(
            .REG_W    (REG_W),
            .NUM_ENT  (FWD_STAGES),
            .ZERO_REG (ZERO_REG),
            .SW       (SEL_W)
        ) u_fwd (
            .src_i   (exe_src_q[k]),
            .dest_i  (tag_dest),
            .wen_i   (tag_wen),
            .blk_i   (tag_ld & LD_BLK),
            .match_o (fwd_m[k]),
            .sel_o   (fwd_s[k])
        );

        // Entry 0 is EXE, entries 1..FWD_STAGES are the tags; ID only checks older work.
        fwd_match #(
            .REG_W    (REG_W),
            .NUM_ENT  (FWD_STAGES + 1),
            .ZERO_REG (ZERO_REG),
            .SW       (HSW)
        ) u_hz (
            .src_i   (id_src[k*REG_W +: REG_W]),
            .dest_i  ({tag_dest, exe_q.dest}),
            .wen_i   ({tag_wen, exe_q.wb_en}),
            .blk_i   ('0),
            .match_o (hz_m[k]),
            .sel_o   (hz_s[k])
        );

        assign sel[k*SEL_W +: SEL_W] = (fwd_en && exe_used_q[k] && |fwd_m[k]) ? fwd_s[k]
                                                                              : SEL_W'(SEL_RF);
        assign hz_op[k] = id_valid && id_src_used[k] &&
                          (fwd_en ? (hz_s[k] == HSW'(1) && exe_q.mem_read) : |hz_m[k]);
    end

    assign hazard_stall = !flush && |hz_op;
    assign stall_count  = cnt_q;

    always_comb begin
        exe_src_d  = exe_src_q;
        exe_used_d = exe_used_q;
        exe_d      = exe_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        if (!mem_stall) begin
            tag_d[0] = exe_q;
            for (int i = 1; i < FWD_STAGES; i++)
                tag_d[i] = tag_q[i-1];
            exe_src_d  = '0;
            exe_used_d = '0;
            exe_d      = fwd_bubble();
            // hazard_stall is already low under flush, so flush keeps priority.
            if (hazard_stall) begin
                if (cnt_q != 16'hFFFF)
                    cnt_d = cnt_q + 16'd1;
            end else if (!flush && id_valid) begin
                exe_src_d      = id_src;
                exe_used_d     = id_src_used;
                exe_d.dest     = FWD_DEST_W'(id_dest);
                exe_d.wb_en    = id_wb_en;
                exe_d.mem_read = id_mem_read;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_src_q  <= '0;
            exe_used_q <= '0;
            exe_q      <= fwd_bubble();
            tag_q      <= {FWD_STAGES{fwd_bubble()}};
            cnt_q      <= '0;
        end else begin
            exe_src_q  <= exe_src_d;
            exe_used_q <= exe_used_d;
            exe_q      <= exe_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
